// File: rtl/seq_detect_ctrl.sv
// Serial 1010 detector (overlapping) with run controller: start/stop/ack, match target, bit window.
// Latency: match, counters and status reflect a bit sampled at edge N right after edge N.
// No backpressure: each bit_valid bit in RUN is consumed on its edge, and bits outside RUN are dropped.
module seq_detect_ctrl #(
  parameter int CNT_W = 8,
  parameter int WIN_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic             ack,
  input  logic             inp,
  input  logic             bit_valid,
  input  logic [CNT_W-1:0] cfg_target,
  input  logic [WIN_W-1:0] cfg_window,
  output logic             busy,
  output logic             done,
  output logic             timeout,
  output logic             match,
  output logic [CNT_W-1:0] match_cnt,
  output logic [WIN_W-1:0] bit_cnt
);

  typedef enum logic [1:0] {IDLE, RUN, DONE, TIMEOUT} state_t;
  // Detector state names the suffix seen so far: none, 1, 10, 101.
  typedef enum logic [1:0] {S0, S1, S2, S3} det_t;

  state_t           state_q;
  det_t             det_q;
  det_t             det_d;
  logic             hit_d;
  logic [CNT_W-1:0] tgt_q;
  logic [WIN_W-1:0] win_q;
  logic [CNT_W-1:0] match_cnt_q;
  logic [CNT_W-1:0] match_cnt_d;
  logic [WIN_W-1:0] bit_cnt_q;
  logic [WIN_W-1:0] bit_cnt_d;
  logic             match_q;
  logic             busy_q;
  logic             done_q;
  logic             timeout_q;

  // Next detector state, match hit and incremented counters for the current input bit.
  always_comb begin
    det_d = det_q;
    hit_d = 1'b0;
    case (det_q)
      S0: det_d = inp ? S1 : S0;
      S1: det_d = inp ? S1 : S2;
      S2: det_d = inp ? S3 : S0;
      S3: begin
        det_d = inp ? S1 : S2;
        hit_d = ~inp;
      end
      default: det_d = S0;
    endcase
    // The run always ends at the target before match_cnt can wrap.
    match_cnt_d = match_cnt_q + CNT_W'(1);
    // With no window the bit counter parks at all-ones instead of wrapping.
    bit_cnt_d = (&bit_cnt_q) ? bit_cnt_q : bit_cnt_q + WIN_W'(1);
  end

  // Controller FSM with registered status flags, counters and match pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      det_q       <= S0;
      tgt_q       <= '0;
      win_q       <= '0;
      match_cnt_q <= '0;
      bit_cnt_q   <= '0;
      match_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      match_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            tgt_q       <= cfg_target;
            win_q       <= cfg_window;
            match_cnt_q <= '0;
            bit_cnt_q   <= '0;
            det_q       <= S0;
            if (cfg_target == '0) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= RUN;
              busy_q  <= 1'b1;
            end
          end
        end
        RUN: begin
          // Stop wins over a bit arriving in the same cycle: the bit is dropped.
          if (stop) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else if (bit_valid) begin
            det_q     <= det_d;
            bit_cnt_q <= bit_cnt_d;
            if (hit_d) begin
              match_q     <= 1'b1;
              match_cnt_q <= match_cnt_d;
            end
            // Reaching the target on the last window bit counts as DONE.
            if (hit_d && (match_cnt_d == tgt_q)) begin
              state_q <= DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else if ((win_q != '0) && (bit_cnt_d == win_q)) begin
              state_q   <= TIMEOUT;
              busy_q    <= 1'b0;
              timeout_q <= 1'b1;
            end
          end
        end
        DONE, TIMEOUT: begin
          if (ack) begin
            state_q   <= IDLE;
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign timeout   = timeout_q;
  assign match     = match_q;
  assign match_cnt = match_cnt_q;
  assign bit_cnt   = bit_cnt_q;

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Randomized and directed bench for seq_detect_ctrl with a queue-based scoreboard.
// Expected per-cycle outputs come from a behavioural model built on a bit history.
// A monitor pops one expected snapshot after every edge for which one was issued.
module tb_seq_detect_ctrl;
  localparam int CNT_W = 8;
  localparam int WIN_W = 5;
  localparam int BC_MAX = (1 << WIN_W) - 1;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             start = 1'b0;
  logic             stop = 1'b0;
  logic             ack = 1'b0;
  logic             inp = 1'b0;
  logic             bit_valid = 1'b0;
  logic [CNT_W-1:0] cfg_target = '0;
  logic [WIN_W-1:0] cfg_window = '0;
  logic             busy;
  logic             done;
  logic             timeout;
  logic             match;
  logic [CNT_W-1:0] match_cnt;
  logic [WIN_W-1:0] bit_cnt;

  seq_detect_ctrl #(.CNT_W(CNT_W), .WIN_W(WIN_W)) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .ack(ack),
    .inp(inp), .bit_valid(bit_valid), .cfg_target(cfg_target), .cfg_window(cfg_window),
    .busy(busy), .done(done), .timeout(timeout), .match(match),
    .match_cnt(match_cnt), .bit_cnt(bit_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic             busy;
    logic             done;
    logic             timeout;
    logic             match;
    logic [CNT_W-1:0] mc;
    logic [WIN_W-1:0] bc;
  } snap_t;

  snap_t exp_q[$];
  int checks = 0;
  int errors = 0;

  // Behavioural model: run mode plus the history of bits seen in the current run.
  typedef enum {M_IDLE, M_RUN, M_DONE, M_TO} mmode_t;
  mmode_t     m_mode;
  int         m_tgt, m_win, m_mc, m_bc, m_nb;
  logic [3:0] m_hist;
  bit         m_match;

  task automatic model_reset();
    m_mode = M_IDLE;
    m_tgt = 0; m_win = 0; m_mc = 0; m_bc = 0; m_nb = 0;
    m_hist = 4'b0000;
    m_match = 1'b0;
  endtask

  task automatic model_step(input bit st, input bit sp, input bit ak, input bit b, input bit v);
    snap_t s;
    m_match = 1'b0;
    case (m_mode)
      M_IDLE: if (st) begin
        m_tgt = int'(cfg_target);
        m_win = int'(cfg_window);
        m_mc = 0; m_bc = 0; m_nb = 0; m_hist = 4'b0000;
        m_mode = (m_tgt == 0) ? M_DONE : M_RUN;
      end
      M_RUN: if (sp) begin
        m_mode = M_IDLE;
      end else if (v) begin
        m_hist = {m_hist[2:0], b};
        m_nb++;
        if (m_bc < BC_MAX) m_bc++;
        if (m_nb >= 4 && m_hist == 4'b1010) begin
          m_mc++;
          m_match = 1'b1;
        end
        if (m_match && m_mc == m_tgt) m_mode = M_DONE;
        else if (m_win != 0 && m_bc == m_win) m_mode = M_TO;
      end
      default: if (ak) m_mode = M_IDLE;
    endcase
    s.busy    = (m_mode == M_RUN);
    s.done    = (m_mode == M_DONE);
    s.timeout = (m_mode == M_TO);
    s.match   = m_match;
    s.mc      = CNT_W'(m_mc);
    s.bc      = WIN_W'(m_bc);
    exp_q.push_back(s);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Drive one cycle at the falling edge, issue the expectation, return just after the rising edge.
  task automatic cycle(input bit st, input bit sp, input bit ak, input bit b, input bit v);
    @(negedge clk);
    start = st; stop = sp; ack = ak; inp = b; bit_valid = v;
    model_step(st, sp, ak, b, v);
    @(posedge clk);
    #2;
  endtask

  task automatic idle_cycle();
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic run_start(input int tgt, input int win);
    cfg_target = CNT_W'(tgt);
    cfg_window = WIN_W'(win);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic send_bits(input logic [15:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) cycle(1'b0, 1'b0, 1'b0, bits[i], 1'b1);
  endtask

  // Reset asserted between edges; outputs must clear without a clock edge.
  task automatic async_reset(input bit check_now);
    #1;
    reset = 1'b0;
    #1;
    if (check_now) begin
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_match_cnt", 32'(match_cnt), 32'd0);
      chk("rst_bit_cnt", 32'(bit_cnt), 32'd0);
    end
    model_reset();
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; stop = 1'b0; ack = 1'b0; inp = 1'b0; bit_valid = 1'b0;
    reset = 1'b1;
  endtask

  // Monitor: after each rising edge compare the DUT outputs with the oldest expectation.
  initial begin
    snap_t e;
    snap_t a;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = {busy, done, timeout, match, match_cnt, bit_cnt};
        checks++;
        if (a !== e) begin
          errors++;
          $display("FAIL snap: got b%0b d%0b t%0b m%0b mc%0d bc%0d expected b%0b d%0b t%0b m%0b mc%0d bc%0d",
                   a.busy, a.done, a.timeout, a.match, a.mc, a.bc,
                   e.busy, e.done, e.timeout, e.match, e.mc, e.bc);
        end
      end
    end
  end

  initial begin
    model_reset();
    #3;
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_timeout", 32'(timeout), 32'd0);
    chk("reset_match", 32'(match), 32'd0);
    chk("reset_counts", 32'({match_cnt, bit_cnt}), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    idle_cycle();

    // target 2, no window: 101010 -> matches after bits 4 and 6, done after 6
    run_start(2, 0);
    send_bits(16'b1010, 4);
    chk("t2_match_bit4", 32'(match), 32'd1);
    send_bits(16'b10, 2);
    chk("t2_match_bit6", 32'(match), 32'd1);
    chk("t2_done", 32'(done), 32'd1);
    chk("t2_match_cnt", 32'(match_cnt), 32'd2);
    chk("t2_bit_cnt", 32'(bit_cnt), 32'd6);
    cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("t2_ack_idle", 32'(done), 32'd0);

    // target 3, window 5: 11001 -> timeout
    run_start(3, 5);
    send_bits(16'b11001, 5);
    chk("w5_timeout", 32'(timeout), 32'd1);
    chk("w5_busy", 32'(busy), 32'd0);
    chk("w5_match_cnt", 32'(match_cnt), 32'd0);
    chk("w5_bit_cnt", 32'(bit_cnt), 32'd5);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("to_ignores_start", 32'(timeout), 32'd1);
    cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

    // target 1, window 4: 1010 -> done beats timeout on the final bit
    run_start(1, 4);
    send_bits(16'b1010, 4);
    chk("w4_done", 32'(done), 32'd1);
    chk("w4_no_timeout", 32'(timeout), 32'd0);
    chk("w4_match_cnt", 32'(match_cnt), 32'd1);
    cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

    // target 0: done straight away
    run_start(0, 3);
    chk("t0_done", 32'(done), 32'd1);
    chk("t0_bit_cnt", 32'(bit_cnt), 32'd0);
    cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("t0_ack_idle", 32'({busy, done, timeout}), 32'd0);

    // target 4: 1,0,gap,1 then stop; new start clears counters
    run_start(4, 0);
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    cycle(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("gap_bit_cnt", 32'(bit_cnt), 32'd3);
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("stop_idle", 32'(busy), 32'd0);
    chk("stop_bit_cnt", 32'(bit_cnt), 32'd3);
    chk("stop_match_cnt", 32'(match_cnt), 32'd0);
    run_start(4, 0);
    chk("restart_bit_cnt", 32'(bit_cnt), 32'd0);
    chk("restart_busy", 32'(busy), 32'd1);

    // stop with the completing bit: stop wins
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    run_start(1, 0);
    send_bits(16'b101, 3);
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("stopwin_match", 32'(match), 32'd0);
    chk("stopwin_done", 32'(done), 32'd0);
    chk("stopwin_bit_cnt", 32'(bit_cnt), 32'd3);

    // bit counter saturation with no window
    run_start(200, 0);
    for (int i = 0; i < BC_MAX + 6; i++) cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    chk("sat_bit_cnt", 32'(bit_cnt), BC_MAX);
    chk("sat_busy", 32'(busy), 32'd1);
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

    // async reset mid-run, then a normal run
    run_start(3, 0);
    send_bits(16'b10101, 5);
    async_reset(1'b1);
    run_start(1, 0);
    send_bits(16'b1010, 4);
    chk("post_rst_done", 32'(done), 32'd1);
    chk("post_rst_match_cnt", 32'(match_cnt), 32'd1);
    cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

    // randomized traffic, cfg changes every cycle
    for (int i = 0; i < 3000; i++) begin
      if (i % 700 == 350) async_reset(1'b0);
      cfg_target = CNT_W'($urandom_range(0, 3));
      cfg_window = ($urandom_range(0, 3) == 0) ? '0 : WIN_W'($urandom_range(1, 12));
      cycle($urandom_range(0, 4) == 0, $urandom_range(0, 29) == 0, $urandom_range(0, 3) == 0,
            1'($urandom_range(0, 1)), $urandom_range(0, 9) < 7);
    end

    idle_cycle();
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
